// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU/MEM producer handshakes
// and the registered writeback port toward register_manager.
interface wb_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
);
  logic             alu_v;
  logic [RADDR-1:0] alu_rd;
  logic [XLEN-1:0]  alu_data;
  logic             alu_ok;
  logic             mem_v;
  logic [RADDR-1:0] mem_rd;
  logic [XLEN-1:0]  mem_data;
  logic             mem_ok;
  logic             res_v;
  logic [RADDR-1:0] res_adr;
  logic [XLEN-1:0]  res_data;
  logic             res_ok;
  logic             grant_alu;

  modport slave (
    input  alu_v, alu_rd, alu_data,
    output alu_ok,
    input  mem_v, mem_rd, mem_data,
    output mem_ok,
    output res_v, res_adr, res_data,
    input  res_ok,
    output grant_alu
  );

  modport master (
    output alu_v, alu_rd, alu_data,
    input  alu_ok,
    output mem_v, mem_rd, mem_data,
    input  mem_ok,
    input  res_v, res_adr, res_data,
    output res_ok,
    input  grant_alu
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one holding register per producer,
// round-robin pick into a registered writeback stage.
module wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input logic        clk,
  input logic        rst,
  wb_arbiter_if.slave bus
);
  logic             r_alu_full;
  logic [RADDR-1:0] r_alu_rd;
  logic [XLEN-1:0]  r_alu_data;
  logic             r_mem_full;
  logic [RADDR-1:0] r_mem_rd;
  logic [XLEN-1:0]  r_mem_data;
  logic             r_res_v;
  logic [RADDR-1:0] r_res_adr;
  logic [XLEN-1:0]  r_res_data;
  logic             r_grant_alu;

  logic w_out_free;
  logic w_gnt_alu;
  logic w_gnt_mem;
  logic w_alu_ok;
  logic w_mem_ok;
  logic w_alu_load;
  logic w_mem_load;

  // Output slot is free when empty or being consumed.
  // On a tie the source not granted last wins.
  assign w_out_free = ~r_res_v | bus.res_ok;
  assign w_gnt_alu  = w_out_free & r_alu_full &
                      (~r_mem_full | ~r_grant_alu);
  assign w_gnt_mem  = w_out_free & r_mem_full &
                      (~r_alu_full | r_grant_alu);

  // ok depends only on state and res_ok, never on src_v.
  assign w_alu_ok = ~r_alu_full | w_gnt_alu;
  assign w_mem_ok = ~r_mem_full | w_gnt_mem;

  // rd==0 results are handshaken but dropped.
  assign w_alu_load = bus.alu_v & w_alu_ok &
                      (bus.alu_rd != '0);
  assign w_mem_load = bus.mem_v & w_mem_ok &
                      (bus.mem_rd != '0);

  assign bus.alu_ok    = w_alu_ok;
  assign bus.mem_ok    = w_mem_ok;
  assign bus.res_v     = r_res_v;
  assign bus.res_adr   = r_res_adr;
  assign bus.res_data  = r_res_data;
  assign bus.grant_alu = r_grant_alu;

  // ALU holding register: reload on accept, clear on grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_full <= 1'b0;
      r_alu_rd   <= '0;
      r_alu_data <= '0;
    end else if (w_alu_load) begin
      r_alu_full <= 1'b1;
      r_alu_rd   <= bus.alu_rd;
      r_alu_data <= bus.alu_data;
    end else if (w_gnt_alu) begin
      r_alu_full <= 1'b0;
    end
  end

  // MEM holding register: reload on accept, clear on grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_full <= 1'b0;
      r_mem_rd   <= '0;
      r_mem_data <= '0;
    end else if (w_mem_load) begin
      r_mem_full <= 1'b1;
      r_mem_rd   <= bus.mem_rd;
      r_mem_data <= bus.mem_data;
    end else if (w_gnt_mem) begin
      r_mem_full <= 1'b0;
    end
  end

  // Writeback stage: load the winner or retire on res_ok.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_v     <= 1'b0;
      r_res_adr   <= '0;
      r_res_data  <= '0;
      r_grant_alu <= 1'b0;
    end else if (w_gnt_alu) begin
      r_res_v     <= 1'b1;
      r_res_adr   <= r_alu_rd;
      r_res_data  <= r_alu_data;
      r_grant_alu <= 1'b1;
    end else if (w_gnt_mem) begin
      r_res_v     <= 1'b1;
      r_res_adr   <= r_mem_rd;
      r_res_data  <= r_mem_data;
      r_grant_alu <= 1'b0;
    end else if (bus.res_ok) begin
      r_res_v     <= 1'b0;
    end
  end
endmodule
